// File: rtl/obuf_ctrl_pkg.sv
// Shared types and constants for the obuf memory-side controller.
// State encoding, requester ids and skid FIFO depth.
package obuf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_e;

  localparam logic REQ_LD = 1'b0;
  localparam logic REQ_ST = 1'b1;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/obuf_skid_fifo.sv
// Purpose: SKID_DEPTH-entry FIFO absorbing the obuf read latency on the store path.
// Latency: pushed word visible at head the cycle after push.
// Backpressure: none internally; the caller never pushes when full or pops when empty.
module obuf_skid_fifo
  import obuf_ctrl_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

endmodule

// File: rtl/obuf_mem_ctrl.sv
// Purpose: arbitrates LOAD/STORE bursts onto the obuf mem port (perf counters under OBUF_MEM_CTRL_PERF_EN).
// Latency: grant 1 cycle after start latches; first store word 2 cycles after grant; done 1 cycle after last beat.
// Backpressure: ld_ready only during an active load; store reads throttle so in-flight + FIFO never exceeds SKID_DEPTH.
module obuf_mem_ctrl
  import obuf_ctrl_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int LEN_W          = 11
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_start,
  input  logic [MEM_ADDR_WIDTH-1:0] ld_base_addr,
  input  logic [LEN_W-1:0]          ld_num_words,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [MEM_DATA_WIDTH-1:0] ld_data,
  output logic                      ld_done,
  input  logic                      st_start,
  input  logic [MEM_ADDR_WIDTH-1:0] st_base_addr,
  input  logic [LEN_W-1:0]          st_num_words,
  output logic                      st_valid,
  input  logic                      st_ready,
  output logic [MEM_DATA_WIDTH-1:0] st_data,
  output logic                      st_done,
`ifdef OBUF_MEM_CTRL_PERF_EN
  output logic [31:0]               perf_st_stall_cycles,
  output logic [31:0]               perf_arb_wait_cycles,
`endif
  output logic                      mem_write_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
  output logic                      mem_read_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_read_data
);

  state_e                    state_q;
  logic                      ld_pend_q, st_pend_q;
  logic                      rr_q;
  logic                      outst_q;
  logic                      ld_done_q, st_done_q;
  logic [MEM_ADDR_WIDTH-1:0] ld_base_q, st_base_q;
  logic [LEN_W-1:0]          ld_len_q, st_len_q;
  logic [LEN_W-1:0]          cnt_q, iss_q;

  logic [1:0]                fifo_cnt;
  logic [1:0]                occ;
  logic [MEM_DATA_WIDTH-1:0] fifo_head;
  logic                      pop;
  logic                      grant_st;
  logic                      ld_acc, st_acc;

  // A start is dropped while its side is pending, active, or signalling done.
  assign ld_acc   = ld_start && !ld_pend_q && (state_q != LOAD) && !ld_done_q;
  assign st_acc   = st_start && !st_pend_q && (state_q != STORE) && !st_done_q;
  assign grant_st = st_pend_q && (!ld_pend_q || (rr_q == REQ_ST));

  assign ld_ready       = (state_q == LOAD) && (cnt_q < ld_len_q);
  assign mem_write_req  = ld_ready && ld_valid;
  assign mem_write_addr = mem_write_req ? ld_base_q + MEM_ADDR_WIDTH'(cnt_q) : '0;
  assign mem_write_data = mem_write_req ? ld_data : '0;

  assign st_valid = (fifo_cnt != 2'd0);
  assign st_data  = fifo_head;
  assign pop      = st_valid && st_ready;

  // Occupancy after this cycle's pop; counting the pop keeps 1 word/cycle streaming.
  assign occ           = fifo_cnt + {1'b0, outst_q} - {1'b0, pop};
  assign mem_read_req  = (state_q == STORE) && (iss_q < st_len_q) && (occ < 2'(SKID_DEPTH));
  assign mem_read_addr = mem_read_req ? st_base_q + MEM_ADDR_WIDTH'(iss_q) : '0;

  assign ld_done = ld_done_q;
  assign st_done = st_done_q;

  obuf_skid_fifo #(
    .W(MEM_DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .push_i    (outst_q),
    .push_dat_i(mem_read_data),
    .pop_i     (pop),
    .head_o    (fifo_head),
    .count_o   (fifo_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ld_pend_q <= 1'b0;
      st_pend_q <= 1'b0;
      rr_q      <= REQ_LD;
      outst_q   <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      ld_base_q <= '0;
      st_base_q <= '0;
      ld_len_q  <= '0;
      st_len_q  <= '0;
      cnt_q     <= '0;
      iss_q     <= '0;
    end else begin
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      outst_q   <= mem_read_req;

      if (ld_acc) begin
        ld_pend_q <= 1'b1;
        ld_base_q <= ld_base_addr;
        ld_len_q  <= ld_num_words;
      end
      if (st_acc) begin
        st_pend_q <= 1'b1;
        st_base_q <= st_base_addr;
        st_len_q  <= st_num_words;
      end

      unique case (state_q)
        IDLE: begin
          if (ld_pend_q || st_pend_q) begin
            cnt_q <= '0;
            iss_q <= '0;
            // The pointer only advances on contended grants.
            if (ld_pend_q && st_pend_q) rr_q <= grant_st ? REQ_LD : REQ_ST;
            if (grant_st) begin
              st_pend_q <= 1'b0;
              state_q   <= STORE;
            end else begin
              ld_pend_q <= 1'b0;
              state_q   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (mem_write_req) cnt_q <= cnt_q + LEN_W'(1);
          if ((ld_len_q == '0) || (mem_write_req && (cnt_q == ld_len_q - LEN_W'(1)))) begin
            ld_done_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        STORE: begin
          if (mem_read_req) iss_q <= iss_q + LEN_W'(1);
          if (pop) cnt_q <= cnt_q + LEN_W'(1);
          if ((st_len_q == '0) || (pop && (cnt_q == st_len_q - LEN_W'(1)))) begin
            st_done_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OBUF_MEM_CTRL_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] wait_q, wait_d;

  always_comb begin
    stall_d = stall_q;
    wait_d  = wait_q;
    if (st_valid && !st_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (((ld_pend_q && (state_q == STORE)) || (st_pend_q && (state_q == LOAD))) && (wait_q != '1))
      wait_d = wait_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      wait_q  <= '0;
    end else begin
      stall_q <= stall_d;
      wait_q  <= wait_d;
    end
  end

  assign perf_st_stall_cycles = stall_q;
  assign perf_arb_wait_cycles = wait_q;
`endif

endmodule

// File: tb/tb_obuf_mem_ctrl.sv
// Scoreboard bench for obuf_mem_ctrl: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_obuf_mem_ctrl;

  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 11;
  localparam int OW = 6 + 3 * DW + 2 * AW;
  localparam logic [DW-1:0] DBASE = 64'hC0DE_0000_0000_0000;
  localparam int K_WR = 0, K_ST = 1, K_LDD = 2, K_STD = 3;

  typedef struct {
    int          kind;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int          cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_start, st_start;
  logic [AW-1:0] ld_base_addr, st_base_addr;
  logic [LW-1:0] ld_num_words, st_num_words;
  logic          ld_valid, ld_ready, ld_done;
  logic [DW-1:0] ld_data;
  logic          st_valid, st_ready, st_done;
  logic [DW-1:0] st_data;
  logic          mem_write_req, mem_read_req;
  logic [AW-1:0] mem_write_addr, mem_read_addr;
  logic [DW-1:0] mem_write_data, mem_read_data;
`ifdef OBUF_MEM_CTRL_PERF_EN
  logic [31:0]   perf_st_stall_cycles, perf_arb_wait_cycles;
`endif

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  ld_beat_exp = 0;
  int  viol = 0;

  obuf_mem_ctrl #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .LEN_W(LW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ld_start      (ld_start),
    .ld_base_addr  (ld_base_addr),
    .ld_num_words  (ld_num_words),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_data       (ld_data),
    .ld_done       (ld_done),
    .st_start      (st_start),
    .st_base_addr  (st_base_addr),
    .st_num_words  (st_num_words),
    .st_valid      (st_valid),
    .st_ready      (st_ready),
    .st_data       (st_data),
    .st_done       (st_done),
`ifdef OBUF_MEM_CTRL_PERF_EN
    .perf_st_stall_cycles(perf_st_stall_cycles),
    .perf_arb_wait_cycles(perf_arb_wait_cycles),
`endif
    .mem_write_req (mem_write_req),
    .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data),
    .mem_read_req  (mem_read_req),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // obuf model: address-tagged data one cycle after a read, all-ones otherwise
  always @(posedge clk) mem_read_data <= mem_read_req ? DW'(mem_read_addr) : '1;

  task automatic push_ev(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_load(input logic [AW-1:0] base, input int len, input int g);
    for (int k = 0; k < len; k++)
      push_ev(K_WR, base + AW'(k), DBASE + 64'(ld_beat_exp + k), g + k);
    push_ev(K_LDD, '0, '0, (len == 0) ? g + 1 : g + len);
    ld_beat_exp += len;
  endtask

  task automatic exp_store(input logic [AW-1:0] base, input int len, input int g, input bit timed);
    logic [AW-1:0] a;
    for (int k = 0; k < len; k++) begin
      a = base + AW'(k);
      push_ev(K_ST, '0, DW'(a), timed ? g + 2 + k : -1);
    end
    push_ev(K_STD, '0, '0, !timed ? -1 : (len == 0) ? g + 1 : g + len + 2);
  endtask

  task automatic check_ev(input string name, input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected: got a=%h d=%h cyc=%0d, required no event", name, a, d, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.a != a || e.d != d || (e.cyc >= 0 && e.cyc != cyc)) begin
      n_fail++;
      $display("FAIL %s: got kind=%0d a=%h d=%h cyc=%0d, required kind=%0d a=%h d=%h cyc=%0d",
               name, kind, a, d, cyc, e.kind, e.a, e.d, e.cyc);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    logic [OW-1:0] v;
    v = {ld_ready, ld_done, st_valid, st_done, mem_write_req, mem_read_req,
         st_data, mem_write_data, mem_write_addr, mem_read_addr};
    n_cmp++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL %s: got outputs=%h, required all zero", name, v);
    end
  endtask

  task automatic pulse(input bit do_ld, input logic [AW-1:0] lb, input int ll,
                       input bit do_st, input logic [AW-1:0] sb, input int sl);
    ld_start = do_ld; ld_base_addr = lb; ld_num_words = LW'(ll);
    st_start = do_st; st_base_addr = sb; st_num_words = LW'(sl);
    @(posedge clk); #1;
    ld_start = 1'b0;
    st_start = 1'b0;
  endtask

  // Load stream source: next word after each accepted beat
  initial begin
    int  beat;
    bit  hs;
    beat    = 0;
    ld_data = DBASE;
    forever begin
      @(negedge clk);
      hs = ld_valid && ld_ready;
      @(posedge clk); #1;
      if (hs) begin
        beat++;
        ld_data = DBASE + 64'(beat);
      end
    end
  end

  // Monitor
  initial begin
    int            rd_tot, pop_tot;
    bit            prev_stall;
    logic [DW-1:0] prev_dat;
    rd_tot = 0; pop_tot = 0; prev_stall = 0; prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rd_tot = 0; pop_tot = 0; prev_stall = 0;
      end else begin
        if (prev_stall) begin
          n_cmp++;
          if (!(st_valid && st_data == prev_dat)) begin
            n_fail++;
            $display("FAIL st_hold: got valid=%0b data=%h, required valid=1 data=%h", st_valid, st_data, prev_dat);
          end
        end
        if (mem_write_req) check_ev("mem_write", K_WR, mem_write_addr, mem_write_data);
        if (st_valid && st_ready) check_ev("st_word", K_ST, '0, st_data);
        if (ld_done) check_ev("ld_done", K_LDD, '0, '0);
        if (st_done) check_ev("st_done", K_STD, '0, '0);
        if (mem_read_req) rd_tot++;
        if (st_valid && st_ready) pop_tot++;
        if (rd_tot - pop_tot > 2) viol++;
        if (mem_write_req && mem_read_req) viol++;
        prev_stall = st_valid && !st_ready;
        prev_dat   = st_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset = 1'b0;
    ld_start = 1'b0; st_start = 1'b0;
    ld_base_addr = '0; ld_num_words = '0; st_base_addr = '0; st_num_words = '0;
    ld_valid = 1'b1; st_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset_state");
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // simultaneous starts after reset: LOAD wins the first tie
    s = cyc;
    exp_load(10'h100, 2, s + 2);
    exp_store(10'h200, 2, s + 5, 1'b1);
    pulse(1'b1, 10'h100, 2, 1'b1, 10'h200, 2);
    repeat (14) @(posedge clk); #1;

    // second tie goes to STORE
    s = cyc;
    exp_store(10'h220, 2, s + 2, 1'b1);
    exp_load(10'h120, 2, s + 7);
    pulse(1'b1, 10'h120, 2, 1'b1, 10'h220, 2);
    repeat (14) @(posedge clk); #1;

    // load wrapping past the top of the address space
    s = cyc;
    exp_load(10'h3FE, 4, s + 2);
    pulse(1'b1, 10'h3FE, 4, 1'b0, '0, 0);
    repeat (10) @(posedge clk); #1;

    // streaming store at full rate
    s = cyc;
    exp_store(10'h010, 3, s + 2, 1'b1);
    pulse(1'b0, '0, 0, 1'b1, 10'h010, 3);
    repeat (10) @(posedge clk); #1;

    // zero-length bursts
    s = cyc;
    exp_load(10'h050, 0, s + 2);
    pulse(1'b1, 10'h050, 0, 1'b0, '0, 0);
    repeat (6) @(posedge clk); #1;
    s = cyc;
    exp_store(10'h060, 0, s + 2, 1'b1);
    pulse(1'b0, '0, 0, 1'b1, 10'h060, 0);
    repeat (6) @(posedge clk); #1;

    // store with st_ready pattern 1,0,0,1
    exp_store(10'h040, 5, 0, 1'b0);
    st_start = 1'b1; st_base_addr = 10'h040; st_num_words = LW'(5);
    for (int i = 0; i < 30; i++) begin
      st_ready = (i % 4 == 0) || (i % 4 == 3);
      @(posedge clk); #1;
      st_start = 1'b0;
    end
    st_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // reset after two of six words: no done, remainder discarded
    s = cyc;
    push_ev(K_ST, '0, DW'(10'h080), s + 4);
    push_ev(K_ST, '0, DW'(10'h081), s + 5);
    pulse(1'b0, '0, 0, 1'b1, 10'h080, 6);
    repeat (5) @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_outputs_zero("reset_mid_store");
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    s = cyc;
    exp_store(10'h300, 2, s + 2, 1'b1);
    pulse(1'b0, '0, 0, 1'b1, 10'h300, 2);
    repeat (10) @(posedge clk); #1;

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d still pending, required 0", exp_q.size());
    end
    n_cmp++;
    if (viol != 0) begin
      n_fail++;
      $display("FAIL port_rules: got %0d overlap/occupancy violations, required 0", viol);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/obuf_mem_ctrl.md
Name: obuf_mem_ctrl

Overview:
- Sequences burst transfers on the memory-side port of the output buffer.
- Two requesters share that single port: LOAD (DRAM stream into obuf, via mem_write) and STORE (obuf out to DRAM stream, via mem_read).
- Arbitrates between them per burst, generates word addresses, and absorbs the 1-cycle obuf read latency with a 2-entry skid FIFO.
- Sits between the DRAM stream interface and the obuf mem_* ports.

Parameters:
- MEM_ADDR_WIDTH, 10, obuf mem-side word address width
- MEM_DATA_WIDTH, 64, word width on obuf mem port and streams
- LEN_W, 11, burst length field width (max 2^LEN_W-1 words)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- ld_start  in  1  pulse: request load burst
- ld_base_addr  in  MEM_ADDR_WIDTH  load start address
- ld_num_words  in  LEN_W  load length
- ld_valid  in  1  load stream data valid
- ld_ready  out  1  load stream ready
- ld_data  in  MEM_DATA_WIDTH  load stream data
- ld_done  out  1  pulse: load burst complete
- st_start  in  1  pulse: request store burst
- st_base_addr  in  MEM_ADDR_WIDTH  store start address
- st_num_words  in  LEN_W  store length
- st_valid  out  1  store stream valid
- st_ready  in  1  store stream ready
- st_data  out  MEM_DATA_WIDTH  store stream data
- st_done  out  1  pulse: store burst complete
- mem_write_req  out  1  obuf mem write strobe
- mem_write_addr  out  MEM_ADDR_WIDTH  obuf mem write address
- mem_write_data  out  MEM_DATA_WIDTH  obuf mem write data
- mem_read_req  out  1  obuf mem read strobe
- mem_read_addr  out  MEM_ADDR_WIDTH  obuf mem read address
- mem_read_data  in  MEM_DATA_WIDTH  obuf read data, valid the cycle after mem_read_req

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; pending flags, counters and FIFO cleared; rr pointer=LOAD.
  - All outputs 0.
  - Reset mid-burst aborts the burst with no done pulse; any in-flight read data is discarded.
- Request latch:
  - ld_start/st_start latch base and length and set that side's pending flag.
  - A start while the same side is pending or active is ignored.
  - Start in the same cycle as that side's done is also ignored.
- States: IDLE, LOAD, STORE.
- IDLE:
  - If exactly one side is pending, grant it next cycle.
  - If both are pending, grant the side not served last (round robin). First tie after reset goes to LOAD.
  - Grant clears that side's pending flag and zeroes its word counter cnt.
- Zero length: a granted burst with num_words==0 pulses done 1 cycle after grant, makes no mem access, and returns to IDLE.
- LOAD:
  - ld_ready=1 only in LOAD.
  - Each ld_valid&&ld_ready cycle: combinationally drive mem_write_req=1, mem_write_addr=base+cnt (mod 2^MEM_ADDR_WIDTH, wraps), mem_write_data=ld_data; then cnt++.
  - After the last word: ld_done=1 for 1 cycle on the next cycle, state goes to IDLE.
- STORE:
  - Issue mem_read_req at address base+issued (wrapping) while issued<num_words and outstanding+fifo_count<2.
  - Returned data is pushed into the FIFO the following cycle.
  - st_valid = FIFO non-empty; st_data = FIFO head. Pop on st_valid&&st_ready. The FIFO never overflows.
  - Throughput: 1 word/cycle with st_ready held high. First st_valid appears 2 cycles after grant.
  - st_valid/st_data stay stable while st_ready==0.
  - After the last pop: st_done=1 for 1 cycle on the next cycle, state goes to IDLE.
- mem_write_req and mem_read_req are never asserted in the same cycle.
- The obuf gives mem_* priority over its buf_* side, so this block carries no backpressure from buf_*.

Optional Feature:
- Macro: OBUF_MEM_CTRL_PERF_EN.
- With the macro:
  - Extra output perf_st_stall_cycles [31:0]: counts cycles with st_valid&&!st_ready.
  - Extra output perf_arb_wait_cycles [31:0]: counts cycles with a side pending while the other is active.
  - Both cleared on reset; saturate at all-ones.
- Without the macro: ports and logic absent.

Decomposition:
- Shared package obuf_ctrl_pkg:
  - state encoding enum (IDLE=0, LOAD=1, STORE=2)
  - requester id constants (REQ_LD=0, REQ_ST=1)
  - SKID_DEPTH=2
- One natural sub-module: obuf_skid_fifo, a 2-entry FIFO with count output, instantiated on the store path.

Test Plan:
- Load base=0x3FE, len=4, ld_valid held high → writes at 0x3FE, 0x3FF, 0x000, 0x001; ld_done 1 cycle after 4th write.
- Store base=0x010, len=3, st_ready=1, obuf model returns addr-tagged data → st_data 0x10, 0x11, 0x12 on consecutive cycles, first st_valid 2 cycles after grant; st_done 1 cycle after last pop.
- Store len=5 with st_ready toggling 1,0,0,1,… → no word lost or duplicated, outstanding+FIFO ≤2, st_data stable while stalled.
- ld_start and st_start in the same cycle after reset → LOAD served first, then STORE; a repeat of both → STORE first.
- len=0 on each side → done pulse 1 cycle after grant, zero mem_*_req.
- reset pulled low mid-store after 2 of 6 words → all outputs 0 immediately, no st_done; a new store after release completes normally.
